vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 110 +++++++++++
 tb/tb_vga_timing_gen.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA 640x480@60 raster timing generator: pixel/line counters, syncs, blanking and frame counter.
// Define VGA_PIPE_ALIGN_EN to delay hs/vs/blank by two clocks to line up with the ROM + RGB register path.
module vga_timing_gen #(
  parameter int H_VISIBLE    = 640,
  parameter int H_TOTAL      = 800,
  parameter int V_VISIBLE    = 480,
  parameter int V_TOTAL      = 525,
  parameter int H_SYNC_START = 656,
  parameter int H_SYNC_END   = 751,
  parameter int V_SYNC_START = 490,
  parameter int V_SYNC_END   = 491
) (
  input  logic       vga_clk,
  input  logic       Reset_n,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic       sync,
  output logic       frame_end,
  output logic [7:0] frame_cnt
);

  localparam logic [9:0] H_MAX = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS = 10'(V_VISIBLE);
  localparam logic [9:0] HS_LO = 10'(H_SYNC_START);
  localparam logic [9:0] HS_HI = 10'(H_SYNC_END);
  localparam logic [9:0] VS_LO = 10'(V_SYNC_START);
  localparam logic [9:0] VS_HI = 10'(V_SYNC_END);

  logic [9:0] x_next;
  logic [9:0] y_next;
  logic       x_wrap;
  logic       y_wrap;
  logic       hs_d;
  logic       vs_d;
  logic       blank_d;
  logic       fe_d;
  logic       hs_r;
  logic       vs_r;
  logic       blank_r;

  // Decode from the next counter values so the registered flags describe the
  // position that is presented alongside them.
  always_comb begin
    x_wrap  = (DrawX == H_MAX);
    y_wrap  = (DrawY == V_MAX);
    x_next  = x_wrap ? 10'd0 : DrawX + 10'd1;
    y_next  = DrawY;
    if (x_wrap) begin
      y_next = y_wrap ? 10'd0 : DrawY + 10'd1;
    end
    hs_d    = !((x_next >= HS_LO) && (x_next <= HS_HI));
    vs_d    = !((y_next >= VS_LO) && (y_next <= VS_HI));
    blank_d = (x_next < H_VIS) && (y_next < V_VIS);
    fe_d    = (x_next == H_MAX) && (y_next == V_MAX);
  end

  always_ff @(posedge vga_clk) begin
    if (!Reset_n) begin
      DrawX     <= 10'd0;
      DrawY     <= 10'd0;
      hs_r      <= 1'b1;
      vs_r      <= 1'b1;
      blank_r   <= 1'b1;
      frame_end <= 1'b0;
      frame_cnt <= 8'd0;
    end else begin
      DrawX     <= x_next;
      DrawY     <= y_next;
      hs_r      <= hs_d;
      vs_r      <= vs_d;
      blank_r   <= blank_d;
      frame_end <= fe_d;
      if (frame_end) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

`ifdef VGA_PIPE_ALIGN_EN
  logic [2:0] pipe_s1;
  logic [2:0] pipe_s2;

  // Stage order is {hs, vs, blank}; blanked with syncs idle while the pipe fills.
  always_ff @(posedge vga_clk) begin
    if (!Reset_n) begin
      pipe_s1 <= 3'b110;
      pipe_s2 <= 3'b110;
    end else begin
      pipe_s1 <= {hs_r, vs_r, blank_r};
      pipe_s2 <= pipe_s1;
    end
  end

  assign hs    = pipe_s2[2];
  assign vs    = pipe_s2[1];
  assign blank = pipe_s2[0];
`else
  assign hs    = hs_r;
  assign vs    = vs_r;
  assign blank = blank_r;
`endif

  assign sync = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size instance for line timing, scaled instance for frame/wrap behaviour.
module tb_vga_timing_gen;

  localparam int W = 30;
`ifdef VGA_PIPE_ALIGN_EN
  localparam int   PIPE_D    = 2;
  localparam logic RST_BLANK = 1'b0;
`else
  localparam int   PIPE_D    = 0;
  localparam logic RST_BLANK = 1'b1;
`endif

  logic       vga_clk = 1'b0;
  logic       rst_a;
  logic       rst_b;
  logic [9:0] x_a, y_a, x_b, y_b;
  logic       hs_a, vs_a, blank_a, sync_a, fe_a;
  logic       hs_b, vs_b, blank_b, sync_b, fe_b;
  logic [7:0] cnt_a, cnt_b;

  int n_chk  = 0;
  int n_pass = 0;

  vga_timing_gen dut_a (
    .vga_clk(vga_clk), .Reset_n(rst_a), .DrawX(x_a), .DrawY(y_a),
    .hs(hs_a), .vs(vs_a), .blank(blank_a), .sync(sync_a),
    .frame_end(fe_a), .frame_cnt(cnt_a)
  );

  vga_timing_gen #(
    .H_VISIBLE(4), .H_TOTAL(8), .V_VISIBLE(3), .V_TOTAL(6),
    .H_SYNC_START(5), .H_SYNC_END(6), .V_SYNC_START(4), .V_SYNC_END(4)
  ) dut_b (
    .vga_clk(vga_clk), .Reset_n(rst_b), .DrawX(x_b), .DrawY(y_b),
    .hs(hs_b), .vs(vs_b), .blank(blank_b), .sync(sync_b),
    .frame_end(fe_b), .frame_cnt(cnt_b)
  );

  // ---------------- clock ----------------
  always #20 vga_clk = ~vga_clk;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %0h required %0h (t=%0t)", name, got, exp, $time);
  endtask

  int cyc_a = 0;
  int cyc_b = 0;

  task automatic wait_cyc(input int which, input int target);
    int guard;
    guard = 0;
    while (((which == 0) ? cyc_a : cyc_b) != target && guard < 20000) begin
      @(negedge vga_clk);
      guard++;
    end
    if (guard >= 20000) begin
      n_chk++;
      $display("FAIL wait_cyc%0d got %0d required %0d", which,
               (which == 0) ? cyc_a : cyc_b, target);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  int ht [2] = '{800, 8};
  int vt [2] = '{525, 6};
  int hv [2] = '{640, 4};
  int vv [2] = '{480, 3};
  int hs0[2] = '{656, 5};
  int hs1[2] = '{751, 6};
  int vs0[2] = '{490, 4};
  int vs1[2] = '{491, 4};

  int         mx[2];
  int         my[2];
  logic [7:0] mcnt[2];
  logic       m_rn;
  logic       m_fe;
  logic [W-1:0] m_e;
  logic [2:0]   m_d;

  logic [W-1:0] exp_q_a[$];
  logic [W-1:0] exp_q_b[$];
  logic [2:0]   dec_q_a[$];
  logic [2:0]   dec_q_b[$];

  function automatic logic [2:0] decode(input int x, input int y, input int i);
    logic h, v, b;
    h = !(x >= hs0[i] && x <= hs1[i]);
    v = !(y >= vs0[i] && y <= vs1[i]);
    b = (x < hv[i]) && (y < vv[i]);
    return {h, v, b};
  endfunction

  // Expected values are pushed as each clock edge is driven.
  initial forever begin
    @(posedge vga_clk);
    for (int i = 0; i < 2; i++) begin
      m_rn = (i == 0) ? rst_a : rst_b;
      if (!m_rn) begin
        mx[i] = 0; my[i] = 0; mcnt[i] = 8'd0;
        if (i == 0) begin
          dec_q_a.delete();
          for (int k = 0; k < PIPE_D; k++) dec_q_a.push_back(3'b110);
        end else begin
          dec_q_b.delete();
          for (int k = 0; k < PIPE_D; k++) dec_q_b.push_back(3'b110);
        end
      end else begin
        if (mx[i] == ht[i] - 1 && my[i] == vt[i] - 1) mcnt[i] = mcnt[i] + 8'd1;
        mx[i] = mx[i] + 1;
        if (mx[i] == ht[i]) begin
          mx[i] = 0;
          my[i] = (my[i] == vt[i] - 1) ? 0 : my[i] + 1;
        end
      end
      m_fe = m_rn && (mx[i] == ht[i] - 1) && (my[i] == vt[i] - 1);
      m_e  = {10'(mx[i]), 10'(my[i]), m_fe, mcnt[i], 1'b0};
      m_d  = decode(mx[i], my[i], i);
      if (i == 0) begin exp_q_a.push_back(m_e); dec_q_a.push_back(m_d); end
      else        begin exp_q_b.push_back(m_e); dec_q_b.push_back(m_d); end
    end
    cyc_a = rst_a ? cyc_a + 1 : 0;
    cyc_b = rst_b ? cyc_b + 1 : 0;
  end

  int hs_low_a = 0;
  int vs_low_b = 0;
  int fe_cnt_b = 0;

  initial forever begin
    logic [W-1:0] e;
    logic [2:0]   d;
    @(negedge vga_clk);
    if (exp_q_a.size() > 0) begin
      e = exp_q_a.pop_front();
      check("sb_a_count", {x_a, y_a, fe_a, cnt_a, sync_a}, e);
    end
    if (dec_q_a.size() > 0) begin
      d = dec_q_a.pop_front();
      check("sb_a_decode", {hs_a, vs_a, blank_a}, d);
    end
    if (exp_q_b.size() > 0) begin
      e = exp_q_b.pop_front();
      check("sb_b_count", {x_b, y_b, fe_b, cnt_b, sync_b}, e);
    end
    if (dec_q_b.size() > 0) begin
      d = dec_q_b.pop_front();
      check("sb_b_decode", {hs_b, vs_b, blank_b}, d);
    end
    if (rst_a && cyc_a >= 1 && cyc_a <= 800 && !hs_a) hs_low_a++;
    if (rst_b && cyc_b >= 1 && cyc_b <= 48 && !vs_b) vs_low_b++;
    if (rst_b && cyc_b >= 1 && cyc_b <= 12288 && fe_b) fe_cnt_b++;
  end

  // ---------------- directed vectors ----------------
  typedef struct {
    int         cyc;
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       blank;
  } vec_t;

  vec_t tbl[11];

  initial begin
`ifdef VGA_PIPE_ALIGN_EN
    tbl[0]  = '{1,    10'd1,   10'd0, 1'b1, 1'b1, 1'b0};
    tbl[1]  = '{639,  10'd639, 10'd0, 1'b1, 1'b1, 1'b1};
    tbl[2]  = '{640,  10'd640, 10'd0, 1'b1, 1'b1, 1'b1};
    tbl[3]  = '{642,  10'd642, 10'd0, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{656,  10'd656, 10'd0, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{658,  10'd658, 10'd0, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{752,  10'd752, 10'd0, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{799,  10'd799, 10'd0, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{800,  10'd0,   10'd1, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{802,  10'd2,   10'd1, 1'b1, 1'b1, 1'b1};
    tbl[10] = '{1599, 10'd799, 10'd1, 1'b1, 1'b1, 1'b0};
`else
    tbl[0]  = '{1,    10'd1,   10'd0, 1'b1, 1'b1, 1'b1};
    tbl[1]  = '{639,  10'd639, 10'd0, 1'b1, 1'b1, 1'b1};
    tbl[2]  = '{640,  10'd640, 10'd0, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{642,  10'd642, 10'd0, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{656,  10'd656, 10'd0, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{658,  10'd658, 10'd0, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{752,  10'd752, 10'd0, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{799,  10'd799, 10'd0, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{800,  10'd0,   10'd1, 1'b1, 1'b1, 1'b1};
    tbl[9]  = '{802,  10'd2,   10'd1, 1'b1, 1'b1, 1'b1};
    tbl[10] = '{1599, 10'd799, 10'd1, 1'b1, 1'b1, 1'b0};
`endif

    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (3) @(negedge vga_clk);
    check("rst_x",     x_a,     0);
    check("rst_y",     y_a,     0);
    check("rst_hs",    hs_a,    1);
    check("rst_vs",    vs_a,    1);
    check("rst_blank", blank_a, RST_BLANK);
    check("rst_fe",    fe_a,    0);
    check("rst_cnt",   cnt_a,   0);
    check("rst_sync",  sync_a,  0);

    rst_a = 1'b1;
    for (int i = 0; i < 11; i++) begin
      wait_cyc(0, tbl[i].cyc);
      check($sformatf("vec%0d_x", i),     x_a,     tbl[i].x);
      check($sformatf("vec%0d_y", i),     y_a,     tbl[i].y);
      check($sformatf("vec%0d_hs", i),    hs_a,    tbl[i].hs);
      check($sformatf("vec%0d_vs", i),    vs_a,    tbl[i].vs);
      check($sformatf("vec%0d_blank", i), blank_a, tbl[i].blank);
    end
    check("hs_low_cycles", hs_low_a, 96);

    // Reset in the middle of a line.
    wait_cyc(0, 1900);
    check("mid_x", x_a, 300);
    check("mid_y", y_a, 2);
    rst_a = 1'b0;
    @(negedge vga_clk);
    check("mid_rst_x",   x_a,   0);
    check("mid_rst_y",   y_a,   0);
    check("mid_rst_hs",  hs_a,  1);
    check("mid_rst_vs",  vs_a,  1);
    check("mid_rst_cnt", cnt_a, 0);
    rst_a = 1'b1;
    @(negedge vga_clk);
    check("mid_rel_x", x_a, 1);
    check("mid_rel_y", y_a, 0);

    // Scaled instance: 8x6 raster, 48 clocks per frame.
    rst_b = 1'b1;
    wait_cyc(1, 47);
    check("fe_x",  x_b,  7);
    check("fe_y",  y_b,  5);
    check("fe_hi", fe_b, 1);
    wait_cyc(1, 48);
    check("f1_x",   x_b,   0);
    check("f1_y",   y_b,   0);
    check("f1_fe",  fe_b,  0);
    check("f1_cnt", cnt_b, 1);
    wait_cyc(1, 48 * 255);
    check("cnt_255", cnt_b, 255);
    wait_cyc(1, 48 * 256);
    check("cnt_wrap", cnt_b, 0);
    wait_cyc(1, 48 * 256 + 4);
    check("vs_low_cycles", vs_low_b, 8);
    check("fe_pulses", fe_cnt_b, 256);

    // Reset with frame_cnt=3 part-way through a frame.
    wait_cyc(1, 48 * 259 + 19);
    check("pre_x",   x_b,   3);
    check("pre_y",   y_b,   2);
    check("pre_cnt", cnt_b, 3);
    rst_b = 1'b0;
    @(negedge vga_clk);
    check("b_rst_x",   x_b,   0);
    check("b_rst_y",   y_b,   0);
    check("b_rst_cnt", cnt_b, 0);
    check("b_rst_hs",  hs_b,  1);
    check("b_rst_vs",  vs_b,  1);
    rst_b = 1'b1;
    @(negedge vga_clk);
    check("b_rel_x", x_b, 1);
    check("b_rel_y", y_b, 0);

    repeat (4) @(negedge vga_clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
